// File: rtl/uart_tx_arbiter_if.sv
// Client/TX-core handshake bundle for the UART transmit arbiter.
// master = environment side (requesters + TX core), slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX core; tx_start one cycle after accept, watchdog on tx_done.
// Backpressure: req_ready only in IDLE, so one byte is in flight until done/timeout plus the gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0)     ? CNT_W'(GAP_CYCLES - 1)     : '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [7:0]      win_data;
  logic [ID_W-1:0] win_next;
  logic            tx_start_c;
  logic            timeout_c;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Priority scan starts at ptr and wraps, so the last winner is served last next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req_valid[rr_index(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(ptr_q, k);
      end
    end
  end

  assign win_data = bus.req_data[{win_idx, 3'b000} +: 8];
  assign win_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    tx_start_c = 1'b0;
    timeout_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          tx_data_d = win_data;
          grant_d   = win_idx;
          ptr_d     = win_next;
          state_d   = START;
        end
      end

      START: begin
        tx_start_c = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_DONE;
      end

      // A done pulse on the expiry cycle takes priority over the watchdog.
      WAIT_DONE: begin
        if (bus.tx_done || (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST)) begin
          timeout_c = !bus.tx_done;
          cnt_d     = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign bus.tx_start    = tx_start_c;
  assign bus.timeout_err = timeout_c;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Random requesters and a TX-core stub against a frame-timeline reference model of the arbiter.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int G   = 6;
  localparam int T   = 120;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .ID_W(IDW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: frame timeline in absolute cycle numbers
  int         m_ptr, m_start, m_free, m_gid, done_cyc;
  bit         m_wait;
  logic [7:0] m_data;

  bit         rv  [N];
  logic [7:0] rd  [N];
  bit         acc [N];
  int stim_mode, dly_mode, dly_fixed, dens;
  bit stray_en, do_reset;

  int         q_gid [$];
  logic [7:0] q_dat [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int         w;
    logic [N-1:0] e_rdy;
    bit         e_start, e_to, e_busy, dn;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      case (stim_mode)
        0: rv[i] = 1'b0;
        1: if (acc[i]) rv[i] = 1'b0;
        2: begin rv[i] = 1'b1; rd[i] = 8'h10 + 8'(i); end
        default: begin
          if (acc[i] || !rv[i]) begin
            rv[i] = ($urandom_range(0, 99) < dens);
            rd[i] = 8'($urandom);
          end else if ($urandom_range(0, 99) < 3) begin
            rv[i] = 1'b0;
          end
        end
      endcase
      acc[i] = 1'b0;
      bus.req_valid[i]       = rv[i];
      bus.req_data[8*i +: 8] = rd[i];
    end
    dn = (cyc == done_cyc) || (stray_en && !m_wait && $urandom_range(0, 29) == 0);
    bus.tx_done = dn;
    reset = do_reset ? 1'b0 : 1'b1;

    @(negedge clk);
    e_rdy = '0; e_start = 1'b0; e_to = 1'b0; e_busy = 1'b1; w = -1;
    if (m_wait) begin
      if (cyc == m_start) e_start = 1'b1;
      else if (dn) begin m_wait = 1'b0; m_free = cyc + G + 1; end
      else if (cyc - m_start == T) begin e_to = 1'b1; m_wait = 1'b0; m_free = cyc + G + 1; end
    end else if (cyc >= m_free) begin
      e_busy = 1'b0;
      for (int k = 0; k < N; k++)
        if (w < 0 && rv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) e_rdy[w] = 1'b1;
    end

    chk("req_ready",   bus.req_ready,   e_rdy);
    chk("tx_start",    bus.tx_start,    e_start);
    chk("timeout_err", bus.timeout_err, e_to);
    chk("busy",        bus.busy,        e_busy);
    chk("tx_data",     bus.tx_data,     m_data);
    chk("grant_id",    bus.grant_id,    m_gid);
    if (bus.tx_start === 1'b1) begin
      q_gid.push_back(int'(bus.grant_id));
      q_dat.push_back(bus.tx_data);
    end

    if (do_reset) begin
      m_ptr = 0; m_wait = 1'b0; m_free = 0; m_data = 8'h00; m_gid = 0;
    end else if (w >= 0) begin
      acc[w]  = 1'b1;
      m_data  = rd[w];
      m_gid   = w;
      m_ptr   = (w + 1) % N;
      m_wait  = 1'b1;
      m_start = cyc + 1;
      case (dly_mode)
        0: done_cyc = m_start + $urandom_range(1, 30);
        1: done_cyc = m_start + dly_fixed;
        2: done_cyc = -1;
        default: begin
          case ($urandom_range(0, 9))
            0: done_cyc = -1;
            1: done_cyc = m_start + T;
            2: done_cyc = m_start + T + 1;
            default: done_cyc = m_start + $urandom_range(1, 40);
          endcase
        end
      endcase
    end
  endtask

  task automatic pulse_reset();
    do_reset = 1'b1;
    step();
    do_reset = 1'b0;
  endtask

  initial begin
    bit reached;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; rd[i] = 8'h00; acc[i] = 1'b0; end
    stim_mode = 0; dly_mode = 0; dly_fixed = 1; dens = 50; stray_en = 1'b0; do_reset = 1'b0;
    m_ptr = 0; m_wait = 1'b0; m_start = -10; m_free = 0; m_data = 8'h00; m_gid = 0; done_cyc = -1;
    repeat (3) @(posedge clk);

    // single requester, done 50 cycles after start
    rv[0] = 1'b1; rd[0] = 8'hAB; stim_mode = 1; dly_mode = 1; dly_fixed = 50;
    repeat (80) step();
    chk("t1_frames", q_gid.size(), 1);
    if (q_gid.size() > 0) begin
      chk("t1_gid", q_gid[0], 0);
      chk("t1_dat", q_dat[0], 8'hAB);
    end

    // all requesters continuously valid from ptr=0
    stim_mode = 0;
    pulse_reset();
    q_gid.delete(); q_dat.delete();
    stim_mode = 2; dly_mode = 0;
    for (int n = 0; n < 400 && q_gid.size() < 5; n++) step();
    chk("t2_frames", (q_gid.size() >= 5), 1);
    for (int k = 0; k < 5 && k < q_gid.size(); k++) begin
      chk("t2_gid", q_gid[k], k % 4);
      chk("t2_dat", q_dat[k], 8'h10 + 8'(k % 4));
    end
    stim_mode = 0;
    repeat (60) step();

    // after a grant to 2, requester 3 beats requester 0
    pulse_reset();
    stim_mode = 1; rv[2] = 1'b1; rd[2] = 8'h22;
    repeat (50) step();
    q_gid.delete(); q_dat.delete();
    rv[0] = 1'b1; rd[0] = 8'h30; rv[3] = 1'b1; rd[3] = 8'h33;
    repeat (100) step();
    chk("t3_frames", q_gid.size(), 2);
    if (q_gid.size() >= 2) begin
      chk("t3_first",  q_gid[0], 3);
      chk("t3_second", q_gid[1], 0);
    end

    // core never finishes, then recovers
    stim_mode = 3; dens = 30; dly_mode = 2;
    repeat (450) step();
    dly_mode = 0;
    repeat (150) step();

    // done on the expiry cycle, stray done pulses while idle
    dly_mode = 1; dly_fixed = T; stray_en = 1'b1;
    repeat (450) step();

    // reset in the middle of WAIT_DONE
    dly_mode = 1; dly_fixed = 25; stray_en = 1'b0; dens = 40;
    for (int r = 0; r < 5; r++) begin
      reached = 1'b0;
      for (int n = 0; n < 200 && !reached; n++) begin
        step();
        if (m_wait && cyc > m_start + 3) reached = 1'b1;
      end
      if (!reached) chk("t6_wait_frame", reached, 1);
      pulse_reset();
      repeat (5) step();
    end

    // mixed random traffic
    dly_mode = 3; stray_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      dens = 10 + p * 25;
      repeat (1000) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
